md_sched_ctrl: RTL and testbench
================================

Name: md_sched_ctrl

Overview:
- Sequencing controller for the E-stage multiply/divide unit and its HI/LO registers.
- Decides when a mult/multu/div/divu launches and suppresses launches killed by an exception/interrupt.
- Times the operation latency, emits the HI/LO commit pulse, and generates the D-stage stall for any HI/LO-related instruction while the unit is occupied.
- Sits between the E-stage decoder/exception logic and the MD datapath; the MD datapath holds no timing state of its own.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (range 1..15).
- OP_W, 3, width of the MD opcode field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- e_valid  in  1  E-stage holds a real (non-bubble) instruction.
- e_op  in  OP_W  MD opcode of the E instruction: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHILO.
- exc_int  in  1  exception or interrupt this cycle; the E instruction must not take effect.
- d_md_use  in  1  D-stage instruction is any MD opcode 1..7.
- start  out  1  one-cycle launch strobe to the MD datapath.
- launch_op  out  OP_W  e_op qualified by start; 0 when start=0.
- mt_hi_we  out  1  write HI from rs this cycle.
- mt_lo_we  out  1  write LO from rs this cycle.
- busy  out  1  operation in flight.
- hilo_we  out  1  one-cycle pulse: copy the internal result into HI/LO.
- cycles_left  out  4  remaining busy cycles.
- stall_d  out  1  freeze PC/F/D and insert a bubble into E.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- FSM states: IDLE, RUN; 4-bit down-counter cnt drives cycles_left; op_is_div register.
- Reset: state IDLE, cnt 0, busy 0, proto_err 0. While reset=1, all combinational outputs are forced to 0: start, launch_op, mt_hi_we, mt_lo_we, hilo_we, stall_d.
- muldiv = e_op in 1..4.
- start = state IDLE & e_valid & muldiv & !exc_int. This is combinational in the launch cycle T.
- Launch at edge T:
  - state goes to RUN.
  - cnt loads MULT_CYCLES for ops 1/2, DIV_CYCLES for ops 3/4.
- RUN:
  - busy = 1 and cnt decrements by 1 each cycle.
  - hilo_we = (cnt == 1), a combinational pulse in cycle T+N.
  - At edge T+N: state goes to IDLE, cnt goes to 0.
  - busy is high exactly in cycles T+1..T+N, and a dependent mfhi/mflo may sit in E at T+N+1.
- mt_hi_we = e_valid & e_op==MTHI & !exc_int & IDLE. mt_lo_we is the same for MTLO. They are combinational and single-cycle.
- stall_d = d_md_use & (busy | start).
  - Covers launch-cycle back-to-back ops.
  - Releases in cycle T+N+1, so the D instruction enters E at T+N+2.
- exc_int during RUN does not cancel or shorten the in-flight op; the launching instruction has already retired.
- exc_int in the launch cycle: start=0, no state change, the op is dropped.
- e_valid & muldiv while in RUN: this is a protocol violation (stall_d should prevent it). The op is ignored, the counter is unaffected, and proto_err is set until reset.
- MTHI/MTLO in E while in RUN: write enables stay 0 and proto_err is set.
- Reset mid-operation: state returns to IDLE on the next edge, no hilo_we is emitted, and the result is discarded.
- Counter never underflows; in IDLE, cnt holds at 0.

Decomposition:
- md_pkg holds:
  - the opcode constants (NONE..MFHILO) and OP_W;
  - the default MULT_CYCLES/DIV_CYCLES;
  - the FSM state encodings;
  - the is_muldiv function.
- One sub-module, md_lat_counter: loadable 4-bit down-counter with done (cnt==1) and zero flags.

Test Plan:
- MULT launch at cycle 10 with d_md_use=1 throughout -> start=1 at 10; busy=1 at 11..15; hilo_we=1 only at 15; cycles_left 5,4,3,2,1 at 11..15; stall_d=1 at 10..15 and 0 at 16.
- DIVU at cycle 20 with exc_int=1 at 24 -> no effect on the op; busy 21..30; hilo_we at 30; proto_err stays 0.
- MULT with exc_int=1 in the launch cycle -> start=0, busy stays 0, cycles_left=0, no hilo_we.
- MTHI in E while IDLE -> mt_hi_we=1 for one cycle. Forced MTLO in E during a DIV run -> mt_lo_we=0 and proto_err latches 1.
- Reset asserted at cycle T+3 of a DIV -> busy=0 and cycles_left=0 after the edge; no hilo_we in any later cycle; proto_err cleared.
- Back-to-back MULT then DIV, with DIV in D during MULT's launch -> DIV held (stall_d=1) through T+5 and launched at T+7. Then start=1, cycles_left=10 at T+8, and hilo_we at T+17.

Source files
------------

// File: rtl/md_sched_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencing controller.
// Holds the MD opcode encodings, default operation latencies, FSM state
// encodings and small opcode classification helpers.
package md_sched_ctrl_pkg;

    localparam int OP_W  = 3;
    localparam int CNT_W = 4;

    localparam logic [OP_W-1:0] OP_NONE   = 3'd0;
    localparam logic [OP_W-1:0] OP_MULT   = 3'd1;
    localparam logic [OP_W-1:0] OP_MULTU  = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV    = 3'd3;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'd4;
    localparam logic [OP_W-1:0] OP_MTHI   = 3'd5;
    localparam logic [OP_W-1:0] OP_MTLO   = 3'd6;
    localparam logic [OP_W-1:0] OP_MFHILO = 3'd7;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Ops that occupy the unit for a timed interval.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_ctrl_if.sv
// Handshake bundle between the E-stage decode/exception logic and the MD
// sequencing controller. The master side is the pipeline (drives the E/D
// stage view); the slave side is the controller (drives strobes and stall).
interface md_sched_ctrl_if;
    import md_sched_ctrl_pkg::*;

    // pipeline -> controller
    logic             e_valid;
    logic [OP_W-1:0]  e_op;
    logic             exc_int;
    logic             d_md_use;

    // controller -> pipeline / MD datapath
    logic             start;
    logic [OP_W-1:0]  launch_op;
    logic             mt_hi_we;
    logic             mt_lo_we;
    logic             busy;
    logic             hilo_we;
    logic [CNT_W-1:0] cycles_left;
    logic             stall_d;
    logic             proto_err;
    logic             op_is_div;   // result select for the HI/LO commit

    modport master (
        output e_valid, e_op, exc_int, d_md_use,
        input  start, launch_op, mt_hi_we, mt_lo_we, busy, hilo_we,
               cycles_left, stall_d, proto_err, op_is_div
    );

    modport slave (
        input  e_valid, e_op, exc_int, d_md_use,
        output start, launch_op, mt_hi_we, mt_lo_we, busy, hilo_we,
               cycles_left, stall_d, proto_err, op_is_div
    );

endinterface

// File: rtl/md_sched_ctrl_lat_counter.sv
// Loadable down-counter timing an MD operation; done flags the last cycle.
// Latency: load/decrement take effect on the next edge; flags are combinational from cnt.
// Backpressure: none; decrement is ignored at zero so the count never wraps.
// Ports: clk, reset (sync, active-high), load/load_val, dec -> cnt, done (cnt==1), zero (cnt==0).
module md_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         done,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));
    assign zero = (cnt == '0);

endmodule

// File: rtl/md_sched_ctrl.sv
// Sequences mult/div launches, times their latency, pulses the HI/LO commit and stalls D.
// Latency: start is same-cycle; busy T+1..T+N; hilo_we in T+N; stall_d releases at T+N+1.
// Backpressure: stall_d holds any MD-using D instruction while busy or launching.
// Ports: clk, reset (sync, active-high), md (slave modport of md_sched_ctrl_if).
module md_sched_ctrl
    import md_sched_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    md_sched_ctrl_if.slave md
);

    md_state_t        state;
    logic             busy_q;
    logic             op_is_div_q;
    logic             proto_q;

    logic             in_idle;
    logic             in_run;
    logic             op_muldiv;
    logic             op_mt;
    logic             start_c;
    logic             violation;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             cnt_zero;

    assign in_idle   = (state == ST_IDLE);
    assign in_run    = (state == ST_RUN);
    assign op_muldiv = is_muldiv(md.e_op);
    assign op_mt     = (md.e_op == OP_MTHI) || (md.e_op == OP_MTLO);

    // A launch is killed outright by a same-cycle exception; nothing is retained.
    assign start_c  = !reset && in_idle && md.e_valid && op_muldiv && !md.exc_int;
    assign load_val = is_div(md.e_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // Anything that would touch HI/LO or relaunch while occupied should have
    // been stalled in D; it is dropped here and flagged instead.
    assign violation = in_run && md.e_valid && (op_muldiv || op_mt);

    md_lat_counter #(
        .W(CNT_W)
    ) u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (start_c),
        .load_val (load_val),
        .dec      (in_run && !cnt_zero),
        .cnt      (cnt),
        .done     (cnt_done),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            op_is_div_q <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        state       <= ST_RUN;
                        busy_q      <= 1'b1;
                        op_is_div_q <= is_div(md.e_op);
                    end
                end
                ST_RUN: begin
                    // Exceptions do not shorten the run: the launching
                    // instruction has already retired.
                    if (cnt_done) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            if (violation) begin
                proto_q <= 1'b1;
            end
        end
    end

    assign md.start       = start_c;
    assign md.launch_op   = start_c ? md.e_op : OP_NONE;
    assign md.mt_hi_we    = !reset && in_idle && md.e_valid && (md.e_op == OP_MTHI) && !md.exc_int;
    assign md.mt_lo_we    = !reset && in_idle && md.e_valid && (md.e_op == OP_MTLO) && !md.exc_int;
    assign md.busy        = busy_q;
    // Reset in the final cycle suppresses the commit so the result is discarded.
    assign md.hilo_we     = !reset && in_run && cnt_done;
    assign md.cycles_left = cnt;
    // Including start covers an MD op in D right behind the launching op.
    assign md.stall_d     = !reset && md.d_md_use && (busy_q || start_c);
    assign md.proto_err   = proto_q;
    assign md.op_is_div   = op_is_div_q;

endmodule

// File: tb/tb_md_sched_ctrl.sv
module tb_md_sched_ctrl;
    import md_sched_ctrl_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_sched_ctrl_if bus();

    md_sched_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: the only state is the timeline of the last launch.
    int launch_cyc = -1000;
    int launch_len = 0;
    bit launch_div = 1'b0;
    bit m_proto    = 1'b0;
    bit known      = 1'b0;

    logic       o_start, o_busy, o_hilo, o_stall, o_proto, o_mthi, o_mtlo;
    logic [3:0] o_left;
    int         hilo_seen = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic exc,
                        input logic du, input logic rst);
        bit run, st, mth, mtl, hw;
        int left;
        @(negedge clk);
        bus.e_valid  = v;
        bus.e_op     = op;
        bus.exc_int  = exc;
        bus.d_md_use = du;
        reset        = rst;
        #1;
        run  = (cyc > launch_cyc) && (cyc <= launch_cyc + launch_len);
        left = run ? (launch_cyc + launch_len - cyc + 1) : 0;
        hw   = run && !rst && (cyc == launch_cyc + launch_len);
        st   = !rst && !run && v && (op >= 3'd1) && (op <= 3'd4) && !exc;
        mth  = !rst && !run && v && (op == 3'd5) && !exc;
        mtl  = !rst && !run && v && (op == 3'd6) && !exc;

        chk("start",     8'(bus.start),     8'(st));
        chk("launch_op", 8'(bus.launch_op), st ? 8'(op) : 8'd0);
        chk("hilo_we",   8'(bus.hilo_we),   8'(hw));
        chk("stall_d",   8'(bus.stall_d),   8'(!rst && du && (run || st)));
        chk("mt_hi_we",  8'(bus.mt_hi_we),  8'(mth));
        chk("mt_lo_we",  8'(bus.mt_lo_we),  8'(mtl));
        if (known) begin
            chk("busy",        8'(bus.busy),        8'(run));
            chk("cycles_left", 8'(bus.cycles_left), 8'(left));
            chk("proto_err",   8'(bus.proto_err),   8'(m_proto));
            chk("op_is_div",   8'(bus.op_is_div),   8'(launch_div));
        end

        o_start = bus.start;   o_busy = bus.busy;       o_hilo = bus.hilo_we;
        o_stall = bus.stall_d; o_proto = bus.proto_err; o_left = bus.cycles_left;
        o_mthi  = bus.mt_hi_we; o_mtlo = bus.mt_lo_we;
        if (bus.hilo_we === 1'b1) hilo_seen++;

        @(posedge clk);
        if (rst) begin
            launch_cyc = -1000;
            launch_len = 0;
            launch_div = 1'b0;
            m_proto    = 1'b0;
            known      = 1'b1;
        end else begin
            if (run && v && (op >= 3'd1) && (op <= 3'd6)) m_proto = 1'b1;
            if (st) begin
                launch_cyc = cyc;
                launch_div = (op >= 3'd3);
                launch_len = launch_div ? DIV_N : MULT_N;
            end
        end
        cyc++;
    endtask

    task automatic nop_to(input int n, input logic du);
        while (cyc < n) step(1'b0, OP_NONE, 1'b0, du, 1'b0);
    endtask

    initial begin
        int h0;
        bus.e_valid = 1'b0; bus.e_op = OP_NONE; bus.exc_int = 1'b0; bus.d_md_use = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b0, OP_NONE, 1'b0, 1'b0, 1'b1);
        nop_to(10, 1'b0);
        chk("reset_busy", 8'(o_busy), 8'd0);
        chk("reset_left", 8'(o_left), 8'd0);
        chk("reset_proto", 8'(o_proto), 8'd0);

        // MULT at 10, MD op sitting in D throughout.
        h0 = hilo_seen;
        step(1'b1, OP_MULT, 1'b0, 1'b1, 1'b0);
        chk("mult_start", 8'(o_start), 8'd1);
        step(1'b0, OP_NONE, 1'b0, 1'b1, 1'b0);
        chk("mult_left11", 8'(o_left), 8'd5);
        nop_to(16, 1'b1);
        chk("mult_hilo15", 8'(o_hilo), 8'd1);
        chk("mult_stall15", 8'(o_stall), 8'd1);
        step(1'b0, OP_NONE, 1'b0, 1'b1, 1'b0);
        chk("mult_stall16", 8'(o_stall), 8'd0);
        chk("mult_hilo_cnt", 8'(hilo_seen - h0), 8'd1);

        // DIVU at 20 with an exception mid-run.
        nop_to(20, 1'b0);
        h0 = hilo_seen;
        step(1'b1, OP_DIVU, 1'b0, 1'b0, 1'b0);
        nop_to(24, 1'b0);
        step(1'b0, OP_NONE, 1'b1, 1'b0, 1'b0);
        nop_to(31, 1'b0);
        chk("divu_hilo30", 8'(o_hilo), 8'd1);
        step(1'b0, OP_NONE, 1'b0, 1'b0, 1'b0);
        chk("divu_hilo_cnt", 8'(hilo_seen - h0), 8'd1);
        chk("divu_proto", 8'(o_proto), 8'd0);

        // MULT killed in its launch cycle.
        nop_to(35, 1'b0);
        h0 = hilo_seen;
        step(1'b1, OP_MULT, 1'b1, 1'b0, 1'b0);
        chk("kill_start", 8'(o_start), 8'd0);
        nop_to(40, 1'b0);
        chk("kill_busy", 8'(o_busy), 8'd0);
        chk("kill_hilo_cnt", 8'(hilo_seen - h0), 8'd0);

        // MTHI while idle, then forced MTLO and reset during a DIV.
        step(1'b1, OP_MTHI, 1'b0, 1'b0, 1'b0);
        chk("mthi_we", 8'(o_mthi), 8'd1);
        nop_to(45, 1'b0);
        h0 = hilo_seen;
        step(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0);
        step(1'b0, OP_NONE, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_MTLO, 1'b0, 1'b0, 1'b0);
        chk("mtlo_run_we", 8'(o_mtlo), 8'd0);
        step(1'b0, OP_NONE, 1'b0, 1'b0, 1'b1);
        chk("mtlo_proto", 8'(o_proto), 8'd1);
        step(1'b0, OP_NONE, 1'b0, 1'b0, 1'b0);
        chk("rst_busy", 8'(o_busy), 8'd0);
        chk("rst_left", 8'(o_left), 8'd0);
        chk("rst_proto", 8'(o_proto), 8'd0);
        nop_to(65, 1'b0);
        chk("rst_hilo_cnt", 8'(hilo_seen - h0), 8'd0);

        // Back-to-back MULT then DIV, DIV waiting in D.
        nop_to(70, 1'b0);
        step(1'b1, OP_MULT, 1'b0, 1'b1, 1'b0);
        chk("b2b_stall_T", 8'(o_stall), 8'd1);
        nop_to(76, 1'b1);
        chk("b2b_stall_T5", 8'(o_stall), 8'd1);
        step(1'b0, OP_NONE, 1'b0, 1'b1, 1'b0);
        chk("b2b_stall_T6", 8'(o_stall), 8'd0);
        step(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0);
        chk("b2b_div_start", 8'(o_start), 8'd1);
        step(1'b0, OP_NONE, 1'b0, 1'b0, 1'b0);
        chk("b2b_left_T8", 8'(o_left), 8'd10);
        nop_to(88, 1'b0);
        chk("b2b_hilo_T17", 8'(o_hilo), 8'd1);
        nop_to(95, 1'b0);

        // Random traffic against the timeline model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
